rule_width_packer: RTL and testbench

Parametrised narrow-to-wide stream packer for the rule/PCIe path. It packs RATIO input flits of IN_W bits into one OUT_W-bit beat and carries sop/eop through. It computes a byte-accurate output empty on the final beat. Unlike the fixed 128->512 packer, it is fully valid/ready compliant (no dropped flits under backpressure) and detects malformed packets. It sits between the SME rule emitter and the PCIe/DMA write stream.

---
 rtl/rule_pkg.sv | 23 ++
 rtl/rule_width_packer.sv | 126 ++++++++++++
 tb/tb_rule_width_packer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rule_pkg.sv
// Shared definitions for the rule/PCIe width-packing path: default geometry,
// eop-beat empty computation and the beat sideband payload.
package rule_pkg;

  localparam int unsigned IN_W_DFLT  = 128;
  localparam int unsigned RATIO_DFLT = 4;
  localparam int unsigned SB_EMPTY_W = 16;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [SB_EMPTY_W-1:0] empty;
  } sideband_t;

  // Unused bytes of a beat whose last valid flit sits in lane 'lane'.
  function automatic int unsigned lane_empty(input int unsigned lane,
                                             input int unsigned ratio,
                                             input int unsigned bytes,
                                             input int unsigned empty);
    return (ratio - 1 - lane) * bytes + empty;
  endfunction

endpackage

// File: rtl/rule_width_packer.sv
// Narrow-to-wide valid/ready stream packer: RATIO flits of IN_W bits form one
// OUT_W beat, with sop/eop carry-through, byte-exact empty and malformed-packet count.
module rule_width_packer
  import rule_pkg::*;
#(
  parameter int unsigned IN_W        = IN_W_DFLT,
  parameter int unsigned RATIO       = RATIO_DFLT,
  parameter int unsigned OUT_W       = IN_W * RATIO,
  parameter int unsigned IN_EMPTY_W  = $clog2(IN_W / 8),
  parameter int unsigned OUT_EMPTY_W = $clog2(OUT_W / 8),
  parameter int unsigned ERR_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [IN_EMPTY_W-1:0]  in_empty,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [OUT_EMPTY_W-1:0] out_empty,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int unsigned LANE_W   = $clog2(RATIO);
  localparam int unsigned IN_BYTES = IN_W / 8;

  logic [LANE_W-1:0] r_lane_idx;
  logic [OUT_W-1:0]  r_acc;
  logic              r_first_beat;
  logic              r_in_pkt;
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_data;
  sideband_t         r_sb;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_accept;
  logic              w_drop;
  logic              w_err;
  logic [LANE_W-1:0] w_lane;
  logic              w_first;
  logic              w_complete;
  logic [OUT_W-1:0]  w_merged;
  sideband_t         w_sb;

  // Output stage may take a new beat whenever it is empty or draining.
  assign in_ready  = !r_out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;

  // A sop flit always restarts at lane 0; headless flits are dropped.
  assign w_drop     = !in_sop & !r_in_pkt;
  assign w_err      = w_accept & ((in_sop & r_in_pkt) | w_drop);
  assign w_lane     = in_sop ? '0 : r_lane_idx;
  assign w_first    = in_sop | r_first_beat;
  assign w_complete = (w_lane == LANE_W'(RATIO - 1)) | in_eop;

  // Merge the incoming flit; lanes above it are forced to zero.
  always_comb begin
    w_merged = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (LANE_W'(k) == w_lane) begin
        w_merged[k*IN_W +: IN_W] = in_data;
      end else if ((LANE_W'(k) < w_lane) && !in_sop) begin
        w_merged[k*IN_W +: IN_W] = r_acc[k*IN_W +: IN_W];
      end
    end
  end

  always_comb begin
    w_sb       = '0;
    w_sb.sop   = w_first;
    w_sb.eop   = in_eop;
    if (in_eop) begin
      w_sb.empty = SB_EMPTY_W'(lane_empty(32'(w_lane), RATIO, IN_BYTES, 32'(in_empty)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane_idx   <= '0;
      r_acc        <= '0;
      r_first_beat <= 1'b1;
      r_in_pkt     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_sb         <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (w_accept && !w_drop) begin
        if (w_complete) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= w_merged;
          r_sb         <= w_sb;
          r_acc        <= '0;
          r_lane_idx   <= '0;
          r_first_beat <= in_eop;
          r_in_pkt     <= !in_eop;
        end else begin
          r_acc        <= w_merged;
          r_lane_idx   <= w_lane + 1'b1;
          r_first_beat <= w_first;
          r_in_pkt     <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sop   = r_sb.sop;
  assign out_eop   = r_sb.eop;
  assign out_empty = OUT_EMPTY_W'(r_sb.empty);
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rule_width_packer.sv
// Self-checking bench for rule_width_packer: packet-level reference model
// turns each packet's flit list into expected output beats.
module tb_rule_width_packer;

  localparam int unsigned IN_W  = 128;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned IEW   = 4;
  localparam int unsigned OEW   = 6;
  localparam int unsigned ERR_W = 16;
  localparam int unsigned BYTES = IN_W / 8;

  typedef struct packed {
    logic            sop;
    logic            eop;
    logic [OEW-1:0]  empty;
    logic [OUT_W-1:0] data;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_sop;
  logic             in_eop;
  logic [IEW-1:0]   in_empty;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sop;
  logic             out_eop;
  logic [OEW-1:0]   out_empty;
  logic [ERR_W-1:0] err_cnt;

  int    total;
  int    bad;
  int    stall_cnt;
  bit    done_flag;
  beat_t exp_q[$];
  beat_t got_q[$];

  rule_width_packer #(
    .IN_W(IN_W), .RATIO(RATIO), .OUT_W(OUT_W),
    .IN_EMPTY_W(IEW), .OUT_EMPTY_W(OEW), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every beat handed over downstream.
  always @(negedge clk) begin : monitor
    beat_t b;
    #1;
    if (!rst && out_valid && out_ready) begin
      b.sop   = out_sop;
      b.eop   = out_eop;
      b.empty = out_empty;
      b.data  = out_data;
      got_q.push_back(b);
    end
  end

  function automatic logic [IN_W-1:0] rand_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_flit(input logic [IN_W-1:0] d, input bit sop, input bit eop, input int emp);
    int w;
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_empty = IEW'(emp);
    in_valid = 1'b1;
    w = 0;
    #1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      #1;
      w++;
      stall_cnt++;
    end
    if (w >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Model: n flits fill ceil(n/RATIO) beats lane by lane; the eop beat's
  // empty counts the unfilled lanes plus the last flit's unused bytes.
  task automatic send_pkt(input int n, input int emp);
    logic [IN_W-1:0] f[$];
    int nb;
    beat_t b;
    for (int k = 0; k < n; k++) f.push_back(rand_flit());
    nb = (n + RATIO - 1) / RATIO;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int k = bi * RATIO; k < n && k < (bi + 1) * RATIO; k++)
        b.data[(k % RATIO) * IN_W +: IN_W] = f[k];
      b.sop = (bi == 0);
      b.eop = (bi == nb - 1);
      b.empty = b.eop ? OEW'((nb * RATIO - n) * BYTES + emp) : '0;
      exp_q.push_back(b);
    end
    for (int k = 0; k < n; k++)
      send_flit(f[k], k == 0, k == n - 1, (k == n - 1) ? emp : int'($urandom_range(0, 15)));
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 1000) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    total++; if ({out_sop, out_eop, out_empty} !== '0) begin bad++; $display("FAIL rst_sideband: got sop=%0b eop=%0b empty=%0d, required 0", out_sop, out_eop, out_empty); end
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL rst_err_cnt: got %0d, required 0", err_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b, required 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_packet();
    out_ready = 1'b1;
    stall_cnt = 0;
    send_pkt(8, 0);
    total++; if (stall_cnt != 0) begin bad++; $display("FAIL full_in_ready: stalled %0d cycles, required 0", stall_cnt); end
    wait_drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL full_beat%0d: got sop=%0b eop=%0b empty=%0d data=%h, required sop=%0b eop=%0b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // Short tail beat and single-flit packet: zeroed upper lanes, large empty.
  task automatic test_short_packets();
    send_pkt(5, 3);
    send_pkt(1, 10);
    wait_drain();
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL short_count: got %0d beats, required 3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL short_beat%0d: got sop=%0b eop=%0b empty=%0d data=%h, required sop=%0b eop=%0b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [OUT_W+OEW+1:0] snap;
    int w;
    out_ready = 1'b1;
    fork
      begin
        send_pkt(4, 0);
        send_pkt(4, 0);
      end
      begin
        w = 0;
        while (!out_valid && w < 50) begin @(negedge clk); w++; end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_beat: out_valid=%0b, required 1", out_valid); end
        out_ready = 1'b0;
        snap = {out_data, out_sop, out_eop, out_empty};
        repeat (3) begin
          @(negedge clk);
          total++; if ({out_data, out_sop, out_eop, out_empty} !== snap || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold: out changed or out_valid=%0b, required stable beat", out_valid); end
          total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b, required 0", in_ready); end
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_beat%0d: got sop=%0b eop=%0b empty=%0d data=%h, required sop=%0b eop=%0b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // Restart on sop mid-packet (partial lanes and on a beat boundary), then headless flits.
  task automatic test_sop_errors();
    int e0;
    beat_t b;
    logic [IN_W-1:0] f[4];
    e0 = int'(err_cnt);
    send_flit(rand_flit(), 1'b1, 1'b0, 0);
    send_flit(rand_flit(), 1'b0, 1'b0, 0);
    send_pkt(4, 0);
    wait_drain();
    total++; if (int'(err_cnt) != e0 + 1) begin bad++; $display("FAIL sop_partial_err: got %0d, required %0d", err_cnt, e0 + 1); end
    b = '0;
    for (int k = 0; k < 4; k++) begin
      f[k] = rand_flit();
      b.data[k * IN_W +: IN_W] = f[k];
    end
    b.sop = 1'b1;
    exp_q.push_back(b);
    for (int k = 0; k < 4; k++) send_flit(f[k], k == 0, 1'b0, 0);
    send_pkt(2, 5);
    wait_drain();
    total++; if (int'(err_cnt) != e0 + 2) begin bad++; $display("FAIL sop_lane0_err: got %0d, required %0d", err_cnt, e0 + 2); end
    send_flit(rand_flit(), 1'b0, 1'b0, 0);
    send_flit(rand_flit(), 1'b0, 1'b1, 0);
    wait_drain();
    total++; if (int'(err_cnt) != e0 + 4) begin bad++; $display("FAIL headless_err: got %0d, required %0d", err_cnt, e0 + 4); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sop_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL sop_beat%0d: got sop=%0b eop=%0b empty=%0d data=%h, required sop=%0b eop=%0b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    send_flit(rand_flit(), 1'b1, 1'b0, 0);
    send_flit(rand_flit(), 1'b0, 1'b0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({out_valid, out_sop, out_eop, out_empty} !== '0 || out_data !== '0) begin bad++; $display("FAIL mrst_outputs: got valid=%0b sop=%0b eop=%0b empty=%0d, required all 0", out_valid, out_sop, out_eop, out_empty); end
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL mrst_err_cnt: got %0d, required 0", err_cnt); end
    rst = 1'b0;
    @(negedge clk);
    send_pkt(4, 0);
    wait_drain();
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL mrst_err_after: got %0d, required 0", err_cnt); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL mrst_count: got %0d beats, required 1", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL mrst_beat%0d: got sop=%0b eop=%0b empty=%0d data=%h, required sop=%0b eop=%0b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int e0;
    e0 = int'(err_cnt);
    done_flag = 1'b0;
    fork
      begin
        for (int p = 0; p < 25; p++) send_pkt(int'($urandom_range(1, 12)), int'($urandom_range(0, 15)));
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_drain();
    total++; if (int'(err_cnt) != e0) begin bad++; $display("FAIL rand_err: got %0d, required %0d", err_cnt, e0); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_beat%0d: got sop=%0b eop=%0b empty=%0d data=%h, required sop=%0b eop=%0b empty=%0d data=%h", i,
                 got_q[i].sop, got_q[i].eop, got_q[i].empty, got_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    stall_cnt = 0;
    done_flag = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_empty  = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_packet();
    test_short_packets();
    test_backpressure();
    test_sop_errors();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
